// File: rtl/wb_stage_buffered.sv
// wb_stage_buffered: load alignment, result select and a result FIFO ahead of the regfile port; WB_INSTRET_EN enables the instret counter
module wb_stage_buffered #(
  parameter int INST_WIDTH = 32,
  parameter int INST_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int REGISTER_ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           mem_valid,
  output logic                           mem_ready,
  input  logic [INST_WIDTH-1:0]          inst_i,
  input  logic                           reg_write_i,
  input  logic [1:0]                     result_sel_i,
  input  logic [DATA_WIDTH-1:0]          alu_res_i,
  input  logic [DATA_WIDTH-1:0]          mem_rdata_i,
  input  logic [DATA_WIDTH-1:0]          csr_rdata_i,
  input  logic [INST_ADDR_WIDTH-1:0]     pc_plus_4_i,
  input  logic [2:0]                     funct3_i,
  input  logic [REGISTER_ADDR_WIDTH-1:0] rd_i,
  output logic                           wb_valid,
  input  logic                           wb_ready,
  output logic [INST_WIDTH-1:0]          INST_WB,
  output logic                           reg_write_WB,
  output logic [REGISTER_ADDR_WIDTH-1:0] rd_WB,
  output logic [DATA_WIDTH-1:0]          result_WB,
  output logic [2:0]                     funct3_WB,
  output logic [63:0]                    instret
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OB = $clog2(DATA_WIDTH / 8);
  localparam int W = INST_WIDTH + 1 + REGISTER_ADDR_WIDTH + DATA_WIDTH + 3;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [W-1:0] q [FIFO_DEPTH];
  logic [W-1:0] head, entry;
  logic [OB-1:0] off;
  logic [7:0] b;
  logic [15:0] h;
  logic [31:0] w;
  logic [DATA_WIDTH-1:0] ld, res;
  logic full, empty, push, pop;
  assign full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
  assign empty = wr_ptr == rd_ptr;
  assign mem_ready = !full;
  assign wb_valid = !empty;
  assign push = mem_valid & ~full & ~flush;
  assign pop = ~empty & wb_ready;
  always_comb begin
    off = alu_res_i[OB-1:0];
    b = 8'(mem_rdata_i >> {off, 3'b000});
    h = 16'(mem_rdata_i >> {off[OB-1:1], 4'b0000});
    w = 32'(DATA_WIDTH == 64 ? mem_rdata_i >> {off[OB-1], 5'b00000} : mem_rdata_i);
    ld = funct3_i == 3'b000 ? DATA_WIDTH'($signed(b))
       : funct3_i == 3'b100 ? DATA_WIDTH'(b)
       : funct3_i == 3'b001 ? DATA_WIDTH'($signed(h))
       : funct3_i == 3'b101 ? DATA_WIDTH'(h)
       : funct3_i == 3'b010 ? DATA_WIDTH'($signed(w))
       : funct3_i == 3'b110 ? DATA_WIDTH'(w)
       : mem_rdata_i;
    res = result_sel_i == 2'b00 ? alu_res_i
        : result_sel_i == 2'b01 ? ld
        : result_sel_i == 2'b10 ? DATA_WIDTH'(pc_plus_4_i)
        : csr_rdata_i;
    entry = {inst_i, reg_write_i & (rd_i != '0), rd_i, res, funct3_i};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) q[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) q[wr_ptr[AW-1:0]] <= entry;
      wr_ptr <= wr_ptr + (AW + 1)'(push);
      rd_ptr <= rd_ptr + (AW + 1)'(pop);
    end
  end
  assign head = q[rd_ptr[AW-1:0]];
  assign {INST_WB, reg_write_WB, rd_WB, result_WB, funct3_WB} = head;
`ifdef WB_INSTRET_EN
  always_ff @(posedge clk) begin
    if (rst) instret <= '0;
    else if (pop & ~flush) instret <= instret + 64'd1;
  end
`else
  assign instret = '0;
`endif
endmodule
